sbox_engine: RTL
================

SBOX_ENGINE -- requirements
Module: sbox_engine

Interface
REQ-001 The block SHALL have parameter LANES, default 4: S-boxes applied per cycle; legal values are 1, 2, 4, 8 and 16, and any other value SHALL be an elaboration error.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the in_state block is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an input.
REQ-006 The block SHALL have port in_state, input, 128 bits: the AES state, column-major, with byte k at bits [127-8k:120-8k] (byte 0 = s00).
REQ-007 The block SHALL have port in_inv, input, 1 bit: mode request (1 = InvSubBytes), latched at acceptance.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_state holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port out_state, output, 128 bits: the substituted state, in the same byte order as in_state.
REQ-011 The block SHALL have port busy, output, 1 bit: high while substitution is in progress (state RUN).

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; the work register, the group counter cnt (width max(1, log2(16/LANES))) and the latched mode SHALL be registered.
REQ-013 in_ready SHALL be high when the state is IDLE, or when the state is DONE and out_ready is high; it SHALL be low otherwise.
REQ-014 On an input handshake (in_valid & in_ready), the block SHALL load in_state into the work register, latch in_inv, clear cnt and enter RUN.
REQ-015 Each RUN cycle SHALL replace bytes cnt*LANES through cnt*LANES+LANES-1 of the work register with their S-box images and increment cnt.
REQ-016 After the group with cnt = 16/LANES-1 is processed, the block SHALL enter DONE, and cnt SHALL wrap to 0.
REQ-017 Latency SHALL be exactly 16/LANES cycles from the input-handshake edge to the first cycle of out_valid = 1.
REQ-018 out_valid SHALL be high only in DONE, and out_state SHALL equal the work register.
REQ-019 out_state and out_valid SHALL remain stable while out_valid & !out_ready.
REQ-020 In DONE, out_ready = 0 SHALL hold DONE; out_ready = 1 with in_valid = 0 SHALL go to IDLE; out_ready = 1 with in_valid = 1 SHALL complete both handshakes on the same edge and enter RUN with the new block.
REQ-021 The forward S-box SHALL compute the multiplicative inverse in GF(2^8) modulo 0x11B (0 maps to 0), followed by the FIPS-197 affine transform with constant 0x63.
REQ-022 The inverse S-box SHALL apply the inverse affine transform (constant 0x05) followed by the GF(2^8) inverse.
REQ-023 The S-box SHALL be combinational inside the RUN cycle and SHALL add no pipeline stage.
REQ-024 in_valid, in_state and in_inv SHALL be ignored when no input handshake occurs.

Reset
REQ-025 When rst = 1 at a clock edge, the state SHALL become IDLE, cnt 0, the work register 0, and the latched mode 0.
REQ-026 While rst = 1 and on the first cycle after it, out_valid, busy and out_state SHALL read 0 and in_ready SHALL read 1.
REQ-027 rst SHALL have priority over every handshake; a reset in RUN or DONE SHALL discard the block in flight without emitting it.

Configuration
REQ-028 With the macro SBOX_ENGINE_INV_EN defined, the inverse S-box datapath SHALL be compiled in, and latched in_inv = 1 SHALL select InvSubBytes for the whole block.
REQ-029 Without SBOX_ENGINE_INV_EN, no inverse datapath SHALL exist, in_inv SHALL be ignored, and the forward S-box SHALL always apply.

Verification
REQ-030 Bench 1 (LANES=4): accept in_state = 128'h0 -> out_state = 128'h6363...63 (16 bytes of 0x63), with out_valid first high exactly 4 cycles after the handshake.
REQ-031 Bench 2 (LANES=1 and LANES=16): in_state = 193de3bea0f4e22b9ac68d2ae9f84808 -> out_state = d42711aee0bf98f1b8b45de51e415230, after 16 and 1 cycles respectively.
REQ-032 Bench 3 (backpressure): hold out_ready = 0 for 10 cycles in DONE -> out_valid = 1 and out_state constant throughout, with in_ready = 0 and busy = 0.
REQ-033 Bench 4 (back-to-back): with out_ready = 1 and in_valid = 1 in DONE -> both handshakes occur on the same edge, with no idle cycle, and the second result appears 16/LANES cycles later.
REQ-034 Bench 5 (mid-operation reset): assert rst in the second RUN cycle -> next cycle out_valid = 0, busy = 0, in_ready = 1, and the discarded block is never output.
REQ-035 Bench 6 (with SBOX_ENGINE_INV_EN): in_inv = 1 with d42711aee0bf98f1b8b45de51e415230 -> 193de3bea0f4e22b9ac68d2ae9f84808; without the macro the same stimulus -> the forward S-box of each byte (byte 0: 0xd4 -> 0x48).

Source files
------------

// File: rtl/sbox_engine.sv
// -----------------------------------------------------------------------------
// sbox_engine
//
// Applies the AES SubBytes (or, optionally, InvSubBytes) transform to a
// 128-bit AES state. LANES bytes are substituted per clock, so one block takes
// 16/LANES RUN cycles. The input side is a valid/ready handshake. The output
// side holds the result under backpressure.
//
// Parameters
//   LANES      : S-boxes evaluated per cycle (1, 2, 4, 8 or 16)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous, active-high reset
//   in_valid   : in_state/in_inv are offered
//   in_ready   : block can accept an input this cycle
//   in_state   : AES state, byte k at bits [127-8k -: 8] (byte 0 = s00)
//   in_inv     : 1 = InvSubBytes, latched at acceptance
//   out_valid  : out_state holds a completed result
//   out_ready  : consumer takes the result
//   out_state  : substituted state, same byte order as in_state
//   busy       : substitution in progress (state RUN)
//
// Build option
//   SBOX_ENGINE_INV_EN : when defined, the inverse S-box datapath is compiled
//                        in. When undefined, in_inv is ignored and the forward
//                        S-box always applies.
// -----------------------------------------------------------------------------
module sbox_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
  begin : g_bad_lanes
    $error("sbox_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, modulus x^8 + x^4 + x^3 + x + 1 (0x11B)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // The inverse is a^254 (a^255 = 1 for nonzero a). 254 = 2+4+...+128, so the
  // loop multiplies the successive squares together. 0 naturally maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // b'_i = b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i.
  // This equals the XOR of b rotated left by 0..4 bits, plus 0x63.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SBOX_ENGINE_INV_EN
  // The inverse affine map is the XOR of s rotated left by 1, 3 and 6 bits,
  // plus 0x05. It is applied before the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [127:0]       work_q,  work_d;
  logic               mode_q,  mode_d;
  int                 byte_idx;

  // Reset overrides every other condition. This forces the reset-time outputs
  // regardless of the registered state.
  assign in_ready  = rst || (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = !rst && (state_q == DONE);
  assign busy      = !rst && (state_q == RUN);
  assign out_state = rst ? 128'd0 : work_q;

`ifndef SBOX_ENGINE_INV_EN
  // In the forward-only build, the mode input and mode register have no reader.
  logic unused_mode;
  assign unused_mode = ^{in_inv, mode_q};
`endif

  always_comb begin
    // NOTE: every always_comb target is defaulted first, so a path that
    // leaves it unassigned holds the value instead of inferring a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    mode_d   = mode_q;
    byte_idx = 0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          work_d  = in_state;
`ifdef SBOX_ENGINE_INV_EN
          mode_d  = in_inv;
`else
          mode_d  = 1'b0;
`endif
        end
      end

      RUN: begin
        // Only the LANES bytes of the current group pass through S-boxes.
        // Every other byte of the work register holds its value.
        for (int l = 0; l < LANES; l++) begin
          byte_idx = int'(cnt_q) * LANES + l;
`ifdef SBOX_ENGINE_INV_EN
          work_d[127 - 8*byte_idx -: 8] = mode_q ? inv_sbox(work_q[127 - 8*byte_idx -: 8])
                                                 : fwd_sbox(work_q[127 - 8*byte_idx -: 8]);
`else
          work_d[127 - 8*byte_idx -: 8] = fwd_sbox(work_q[127 - 8*byte_idx -: 8]);
`endif
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // The result leaves and the next block enters on the same edge.
            state_d = RUN;
            cnt_d   = '0;
            work_d  = in_state;
`ifdef SBOX_ENGINE_INV_EN
            mode_d  = in_inv;
`else
            mode_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the work register is reset with the control state. out_state
      // then reads 0 after reset, and a discarded block cannot leak out.
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // flops sample their _d values from before the edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

endmodule
